// File: rtl/seg_scan_if.sv
// Bundles the scanned display lines and the captured-frame outputs.
// The scanner side is the master. The capture block is the slave.
interface seg_scan_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  digit_err;

    modport master (output an, seg, input value, valid, digit_err);
    modport slave  (input an, seg, output value, valid, digit_err);
endinterface

// File: rtl/seg_scan_capture.sv
// Recovers a 4-digit hex value by watching a multiplexed, active-low
// 7-segment scan. A digit is accepted once it has dwelt for STABLE_CYCLES samples.
//
//  state | meaning
//  WAIT  | blank or no candidate digit on the bus
//  DWELL | counting identical samples of one digit
//  HELD  | digit already captured; ignore until the sample changes
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input logic      clk,
    input logic      rst_n,
    seg_scan_if.slave bus
);
    localparam logic [7:0] STABLE_TC = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {WAIT, DWELL, HELD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  an_s, an_p;
    logic [6:0]  seg_s, seg_p;
    logic        blank, same, capture;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        invalid;

    logic [15:0] slots_q;
    logic [3:0]  seen_q, err_q, seen_d, err_d, onehot;
    logic        frame_done_q;
    logic [15:0] value_q;
    logic        valid_q;
    logic [3:0]  digit_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s  <= 4'hF;
            seg_s <= 7'h7F;
            an_p  <= 4'hF;
            seg_p <= 7'h7F;
        end else begin
            an_s  <= bus.an;
            seg_s <= bus.seg;
            an_p  <= an_s;
            seg_p <= seg_s;
        end
    end

    always_comb begin
        blank = 1'b0;
        idx   = 2'd0;
        case (an_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: blank = 1'b1;
        endcase
    end

    always_comb begin
        invalid = 1'b0;
        nib     = 4'h0;
        case (seg_s)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

    assign same = (an_s == an_p) && (seg_s == seg_p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            WAIT: begin
                if (!blank) begin
                    state_d = DWELL;
                    cnt_d   = 8'd1;
                end
            end
            DWELL, HELD: begin
                if (!same) begin
                    state_d = blank ? WAIT : DWELL;
                    cnt_d   = blank ? 8'd0 : 8'd1;
                end else if (state_q == DWELL) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == STABLE_TC) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // A capture landing on the frame-complete cycle starts the next frame.
    assign onehot = 4'b0001 << idx;

    always_comb begin
        seen_d = frame_done_q ? 4'h0 : seen_q;
        err_d  = frame_done_q ? 4'h0 : err_q;
        if (capture) begin
            seen_d = seen_d | onehot;
            err_d  = invalid ? (err_d | onehot) : (err_d & ~onehot);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q      <= 16'h0000;
            seen_q       <= 4'h0;
            err_q        <= 4'h0;
            frame_done_q <= 1'b0;
            value_q      <= 16'h0000;
            valid_q      <= 1'b0;
            digit_err_q  <= 4'h0;
        end else begin
            if (capture)
                slots_q[{idx, 2'b00} +: 4] <= nib;
            seen_q       <= seen_d;
            err_q        <= err_d;
            frame_done_q <= capture && (seen_d == 4'hF);
            valid_q      <= frame_done_q;
            if (frame_done_q) begin
                value_q     <= slots_q;
                digit_err_q <= err_q;
            end
        end
    end

    assign bus.value     = value_q;
    assign bus.valid     = valid_q;
    assign bus.digit_err = digit_err_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed checks of seg_scan_capture with STABLE_CYCLES = 4.
// Expected values are worked out by hand from the segment table.
module tb_seg_scan_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vcnt = 0;
    int   v0;

    seg_scan_if bus ();

    seg_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.valid) vcnt <= vcnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input int n);
        drive(4'hE, s0, n);
        drive(4'hD, s1, n);
        drive(4'hB, s2, n);
        drive(4'h7, s3, n);
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
    endtask

    initial begin
        bus.an  = 4'hF;
        bus.seg = 7'h7F;
        #12;
        check_val("rst_value", 32'(bus.value), 32'h0000);
        check_val("rst_valid", 32'(bus.valid), 32'h0);
        check_val("rst_err",   32'(bus.digit_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 3);

        // Three-cycle dwell is one short of acceptance.
        v0 = vcnt;
        scan(7'h19, 7'h30, 7'h24, 7'h79, 3);
        drive(4'hF, 7'h7F, 10);
        check_val("short_pulses", 32'(vcnt - v0), 32'd0);
        check_val("short_value", 32'(bus.value), 32'h0000);

        // Basic 1234 scan with exact frame latency.
        v0 = vcnt;
        scan(7'h19, 7'h30, 7'h24, 7'h79, 4);
        @(negedge clk);
        check_val("lat_early", 32'(bus.valid), 32'h0);
        @(negedge clk);
        check_val("lat_valid", 32'(bus.valid), 32'h1);
        check_val("v1234_value", 32'(bus.value), 32'h1234);
        check_val("v1234_err", 32'(bus.digit_err), 32'h0);
        drive(4'hF, 7'h7F, 5);
        check_val("v1234_pulses", 32'(vcnt - v0), 32'd1);
        check_val("v1234_hold", 32'(bus.value), 32'h1234);
        check_val("pulse_width", 32'(bus.valid), 32'h0);

        // Digit 2 undecodable.
        v0 = vcnt;
        scan(7'h46, 7'h03, 7'h7F, 7'h08, 4);
        drive(4'hF, 7'h7F, 5);
        check_val("err_value", 32'(bus.value), 32'hA0BC);
        check_val("err_bits", 32'(bus.digit_err), 32'h4);
        check_val("err_pulses", 32'(vcnt - v0), 32'd1);

        // Reset after digits 1..3 are captured discards the partial frame.
        drive(4'hD, 7'h79, 4);
        drive(4'hB, 7'h24, 4);
        drive(4'h7, 7'h30, 4);
        drive(4'hF, 7'h7F, 2);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_value", 32'(bus.value), 32'h0000);
        check_val("arst_err", 32'(bus.digit_err), 32'h0);
        check_val("arst_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vcnt;
        scan(7'h02, 7'h78, 7'h00, 7'h10, 4);
        drive(4'hF, 7'h7F, 5);
        check_val("post_rst_pulses", 32'(vcnt - v0), 32'd1);
        check_val("post_rst_value", 32'(bus.value), 32'h9876);

        // Blank / multi-select selects mid-scan.
        v0 = vcnt;
        drive(4'hE, 7'h00, 4);
        drive(4'hD, 7'h78, 4);
        drive(4'b1100, 7'h02, 10);
        drive(4'hF, 7'h02, 10);
        check_val("blank_pulses", 32'(vcnt - v0), 32'd0);
        drive(4'hB, 7'h02, 4);
        drive(4'h7, 7'h12, 4);
        drive(4'hF, 7'h7F, 5);
        check_val("blank_resume_pulses", 32'(vcnt - v0), 32'd1);
        check_val("blank_resume_value", 32'(bus.value), 32'h5678);

        // Re-dwell of digit 0 overwrites its slot.
        v0 = vcnt;
        drive(4'hE, 7'h40, 4);
        drive(4'hE, 7'h0E, 4);
        drive(4'hD, 7'h10, 4);
        drive(4'hB, 7'h21, 4);
        drive(4'h7, 7'h06, 4);
        drive(4'hF, 7'h7F, 5);
        check_val("redwell_value", 32'(bus.value), 32'hED9F);
        check_val("redwell_pulses", 32'(vcnt - v0), 32'd1);
        check_val("redwell_err", 32'(bus.digit_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (range 2..255): consecutive identical samples needed to accept a digit.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port an, input, 4: multiplexed digit select, active-low; an[k]=0 selects digit k (k=0 least significant).
REQ-005 SHALL have port seg, input, 7: segment lines {g,f,e,d,c,b,a}, active-low.
REQ-006 SHALL have port value, output, 16: last complete frame; digit k in value[4k+3:4k].
REQ-007 SHALL have port valid, output, 1: one-cycle pulse when value/digit_err update.
REQ-008 SHALL have port digit_err, output, 4: bit k set when digit k of the last frame held an undecodable pattern.

Function
REQ-009 SHALL register an and seg once on entry (sample stage), so all decisions use the sampled values and the previous sample.
REQ-010 SHALL decode a sampled seg to a nibble: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9, 0x08->A, 0x03->B, 0x46->C, 0x21->D, 0x06->E, 0x0E->F; any other pattern is invalid and decodes to 0.
REQ-011 SHALL treat a sample as selecting a digit only when exactly one bit of an is 0; otherwise (all 1s or several 0s) the sample is "blank".
REQ-012 SHALL implement dwell FSM states WAIT, DWELL, HELD.
REQ-013 WAIT: on a non-blank sample, load stable count = 1 and go to DWELL; blank stays in WAIT.
REQ-014 DWELL: if the sample equals the previous sample (an and seg), count increments; when count reaches STABLE_CYCLES, capture the digit and go to HELD in that same cycle.
REQ-015 DWELL/HELD: a sample differing from the previous sample restarts the dwell: non-blank -> DWELL with count = 1; blank -> WAIT.
REQ-016 HELD: identical samples cause no further capture (exactly one capture per dwell).
REQ-017 Capture of digit k SHALL store the decoded nibble in frame slot k, set seen[k], and set err slot k if the pattern is invalid (clear it otherwise); re-capture of a seen digit overwrites the slot.
REQ-018 In the cycle after the capture that makes seen = 4'b1111, SHALL copy slots to value and digit_err, pulse valid for one cycle, and clear seen and all err slots.
REQ-019 A capture occurring in the same cycle as the frame-complete update SHALL be accepted into the freshly cleared frame (not lost).
REQ-020 Latency: a digit stable from cycle t (first sampled at t+1) is captured at t+STABLE_CYCLES; frame output follows one cycle after the final capture.
REQ-021 value and digit_err SHALL hold between valid pulses; invalid digits do not suppress the frame.
REQ-022 The stable counter SHALL be no wider than 8 bits and SHALL never wrap (it stops in HELD).

Reset
REQ-023 When rst_n=0, SHALL force immediately: value=0x0000, valid=0, digit_err=4'b0000, seen=0, err slots=0, FSM=WAIT, count=0, sample registers an=4'hF, seg=7'h7F.
REQ-024 Reset asserted mid-dwell or mid-frame SHALL discard all partial captures; after release, capture restarts from WAIT with an empty frame.

Verification
REQ-025 Scan an=E,D,B,7 with seg=0x19,0x30,0x24,0x79 for 4 cycles each -> one valid pulse, value=0x1234, digit_err=0.
REQ-026 Each digit held only 3 cycles (STABLE_CYCLES=4) -> no capture, valid never asserts, value stays 0x0000.
REQ-027 Digit 2 shows seg=0x7F, others valid (0xA,0xB,0xC on digits 3,1,0) -> valid pulse, digit_err=4'b0100, value=0xA0BC.
REQ-028 an=4'b1100 or 4'b1111 for 10 cycles mid-scan -> no capture; frame completes correctly once a proper scan resumes.
REQ-029 Digit 0 captured as 0x40 then re-dwelled as 0x0E before digits 1-3 -> value[3:0]=0xF.
REQ-030 rst_n pulsed low after three digits are captured -> outputs zero asynchronously; the next full scan yields exactly one valid pulse with the new values.
